ls_queue: RTL

LS_QUEUE -- requirements
Module: ls_queue

---
 rtl/ls_queue.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue with CDB operand wakeup and a single memory port.
// Define LS_MISALIGN_CHECK_EN to trap misaligned accesses instead of forcing alignment.

`ifndef LS_QUEUE_TYPES_DEFINED
`define LS_QUEUE_TYPES_DEFINED
`define WORD_T    logic [31:0]
`define REGTAG_T  logic [5:0]
`define REGADDR_T logic [4:0]
`define SINST_T   logic [3:0]
`define UNLOCKED  6'd0
`endif

module ls_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  `SINST_T           in_op,
  input  `REGTAG_T          in_tagx,
  input  `REGTAG_T          in_tagy,
  input  `WORD_T            in_datax,
  input  `WORD_T            in_datay,
  input  `WORD_T            in_imm,
  input  `REGADDR_T         in_target,
  input  logic              cdb_en,
  input  `REGTAG_T          cdb_tag,
  input  `WORD_T            cdb_data,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output `WORD_T            mem_addr,
  output `WORD_T            mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  `WORD_T            mem_rdata,
  output logic              wb_en,
  output `REGADDR_T         wb_target,
  output `WORD_T            wb_data,
  output logic              fault,
  output `WORD_T            fault_addr,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

  state_t state, state_n;

  logic [DEPTH-1:0] ent_valid;
  `SINST_T          ent_op     [DEPTH];
  `REGTAG_T         ent_tagx   [DEPTH];
  `REGTAG_T         ent_tagy   [DEPTH];
  `WORD_T           ent_datax  [DEPTH];
  `WORD_T           ent_datay  [DEPTH];
  `WORD_T           ent_imm    [DEPTH];
  `REGADDR_T        ent_target [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic             push, pop, keep;
  logic             start, done, mis_pop;
  logic             head_ready;
  `SINST_T          hd_op;
  `WORD_T           hd_addr, hd_addr_al;
  logic [1:0]       acc_size;
  logic             acc_zext;
  `REGADDR_T        acc_target;
  logic             kill;

  // Clear the address bits below the access size.
  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] size);
    case (size)
      2'b00:   align_addr = a;
      2'b01:   align_addr = {a[31:1], 1'b0};
      default: align_addr = {a[31:2], 2'b00};
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = 4'b0011 << lane;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Pull the addressed lane out of the read word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] lane,
                                               input logic [1:0] size, input logic zext);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lane, 3'b000} +: 8];
    h = rd[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extract = zext ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = zext ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extract = rd;
    endcase
  endfunction

  assign in_ready   = (count != FULL);
  assign hd_op      = ent_op[head];
  assign hd_addr    = ent_datax[head] + ent_imm[head];
  assign hd_addr_al = align_addr(hd_addr, hd_op[1:0]);
  assign head_ready = ent_valid[head] && (ent_tagx[head] == `UNLOCKED) &&
                      (ent_tagy[head] == `UNLOCKED);

`ifdef LS_MISALIGN_CHECK_EN
  logic hd_mis;
  assign hd_mis = ((hd_op[1:0] == 2'b01) && hd_addr[0]) ||
                  (hd_op[1] && (hd_addr[1:0] != 2'b00));
`endif

  assign push = in_valid && in_ready && !flush;
  assign pop  = done || mis_pop;
  assign keep = (state == REQ) && !mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Issue control: the head is launched only when both operands are present.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    done    = 1'b0;
    mis_pop = 1'b0;
    unique case (state)
      IDLE: begin
        if (head_ready && !flush) begin
`ifdef LS_MISALIGN_CHECK_EN
          if (hd_mis) begin
            mis_pop = 1'b1;
          end else begin
            start   = 1'b1;
            state_n = REQ;
          end
`else
          start   = 1'b1;
          state_n = REQ;
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          done    = 1'b1;
          state_n = (mem_we || kill || flush) ? IDLE : WB;
        end
      end
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pointers and occupancy; a flush keeps only an in-flight head entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= head + PTR_W'(pop);
      tail  <= (state == REQ) ? head + PTR_W'(1) : head;
      count <= keep ? (PTR_W+1)'(1) : '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(push);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
    end else begin
      if (pop) ent_valid[head] <= 1'b0;
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (!(keep && (PTR_W'(i) == head))) ent_valid[PTR_W'(i)] <= 1'b0;
        end
      end
      if (push) ent_valid[tail] <= 1'b1;
    end
  end

  // Entry payload with CDB wakeup, including capture of a same-cycle broadcast on enqueue.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (cdb_en && ent_valid[PTR_W'(i)] && (cdb_tag != `UNLOCKED)) begin
        if (ent_tagx[PTR_W'(i)] == cdb_tag) begin
          ent_tagx[PTR_W'(i)]  <= `UNLOCKED;
          ent_datax[PTR_W'(i)] <= cdb_data;
        end
        if (ent_tagy[PTR_W'(i)] == cdb_tag) begin
          ent_tagy[PTR_W'(i)]  <= `UNLOCKED;
          ent_datay[PTR_W'(i)] <= cdb_data;
        end
      end
    end
    if (push) begin
      ent_op[tail]     <= in_op;
      ent_imm[tail]    <= in_imm;
      ent_target[tail] <= in_target;
      if (cdb_en && (in_tagx != `UNLOCKED) && (cdb_tag == in_tagx)) begin
        ent_tagx[tail]  <= `UNLOCKED;
        ent_datax[tail] <= cdb_data;
      end else begin
        ent_tagx[tail]  <= in_tagx;
        ent_datax[tail] <= in_datax;
      end
      if (cdb_en && (in_tagy != `UNLOCKED) && (cdb_tag == in_tagy)) begin
        ent_tagy[tail]  <= `UNLOCKED;
        ent_datay[tail] <= cdb_data;
      end else begin
        ent_tagy[tail]  <= in_tagy;
        ent_datay[tail] <= in_datay;
      end
    end
  end

  // Memory request and writeback registers; request fields hold until the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      wb_en      <= 1'b0;
      wb_target  <= '0;
      wb_data    <= '0;
      acc_size   <= '0;
      acc_zext   <= 1'b0;
      acc_target <= '0;
      kill       <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      if (start) begin
        mem_req    <= 1'b1;
        mem_we     <= hd_op[3];
        mem_addr   <= hd_addr_al;
        mem_be     <= byte_en(hd_op[1:0], hd_addr_al[1:0]);
        mem_wdata  <= ent_datay[head] << {hd_addr_al[1:0], 3'b000};
        acc_size   <= hd_op[1:0];
        acc_zext   <= hd_op[2];
        acc_target <= ent_target[head];
        kill       <= 1'b0;
      end
      if ((state == REQ) && flush) kill <= 1'b1;
      if (done) begin
        mem_req <= 1'b0;
        if (!mem_we && !kill && !flush) begin
          wb_en     <= 1'b1;
          wb_target <= acc_target;
          wb_data   <= load_extract(mem_rdata, mem_addr[1:0], acc_size, acc_zext);
        end
      end
    end
  end

`ifdef LS_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      fault <= mis_pop;
      if (mis_pop) fault_addr <= hd_addr;
    end
  end
`else
  assign fault      = 1'b0;
  assign fault_addr = '0;
`endif

endmodule
